// File: rtl/particle_raster.sv
`default_nettype none
// ============================================================================
// Module   : particle_raster
// Purpose  : Rasterises N fixed-point particles into a double-buffered LED
//            bitmap, one pixel per clock, committed at a fixed frame period.
// Revision : 1.0 - initial release
// ============================================================================
module particle_raster #(
    parameter int N_PART      = 4,
    parameter int COORD_W     = 16,
    parameter int FRAC_BITS   = 4,
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int R2          = 2,
    parameter int R2_IN       = 1,
    parameter int WAIT_CYCLES = 10000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PART*2*COORD_W-1:0]  pos,
    input  logic [N_PART-1:0]            enable_mask,
    input  logic [1:0]                   mode,
    output logic [GRID_W*GRID_H-1:0]     matrix,
    output logic                         frame_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int NPIX  = GRID_W * GRID_H;
    localparam int PIX_W = (NPIX > 1)   ? $clog2(NPIX)   : 1;
    localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int DW    = COORD_W + 1;
    localparam int D2_W  = 2 * DW;

    localparam logic [D2_W-1:0] R2_V    = D2_W'(R2);
    localparam logic [D2_W-1:0] R2_IN_V = D2_W'(R2_IN);

    localparam logic [1:0] MODE_RING    = 2'b01;
    localparam logic [1:0] MODE_CENTRE  = 2'b10;
    localparam logic [1:0] MODE_PERSIST = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [PIX_W-1:0]              pix;
    logic [COL_W-1:0]              col;
    logic [ROW_W-1:0]              row;
    logic [NPIX-1:0]               back;
    logic [N_PART*2*COORD_W-1:0]   snap_pos;
    logic [N_PART-1:0]             snap_en;
    logic [1:0]                    snap_mode;
    logic                          tick;
    logic [N_PART-1:0]             hits;

    assign tick = (cnt == CNT_W'(WAIT_CYCLES - 1));

    logic signed [COORD_W-1:0] gx [N_PART];
    logic signed [COORD_W-1:0] gy [N_PART];
    logic signed [DW-1:0]      dx [N_PART];
    logic signed [DW-1:0]      dy [N_PART];
    logic signed [D2_W-1:0]    sqx [N_PART];
    logic signed [D2_W-1:0]    sqy [N_PART];
    logic [D2_W-1:0]           d2 [N_PART];

    // One distance checker per particle, shared by every pixel of the scan.
    for (genvar i = 0; i < N_PART; i++) begin : g_part
        assign gx[i]  = $signed(snap_pos[2*COORD_W*i +: COORD_W]) >>> FRAC_BITS;
        assign gy[i]  = $signed(snap_pos[2*COORD_W*i+COORD_W +: COORD_W]) >>> FRAC_BITS;
        assign dx[i]  = $signed({{(DW-COL_W){1'b0}}, col}) - $signed({gx[i][COORD_W-1], gx[i]});
        assign dy[i]  = $signed({{(DW-ROW_W){1'b0}}, row}) - $signed({gy[i][COORD_W-1], gy[i]});
        assign sqx[i] = dx[i] * dx[i];
        assign sqy[i] = dy[i] * dy[i];
        assign d2[i]  = $unsigned(sqx[i]) + $unsigned(sqy[i]);
        assign hits[i] = snap_en[i] & (
            (snap_mode == MODE_RING)   ? ((d2[i] >= R2_IN_V) && (d2[i] <= R2_V)) :
            (snap_mode == MODE_CENTRE) ? (d2[i] == '0) :
                                         (d2[i] <= R2_V));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pix         <= '0;
            col         <= '0;
            row         <= '0;
            back        <= '0;
            snap_pos    <= '0;
            snap_en     <= '0;
            snap_mode   <= '0;
            matrix      <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            cnt <= tick ? '0 : cnt + 1'b1;

            // A tick that lands outside IDLE is dropped and only recorded.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        snap_pos  <= pos;
                        snap_en   <= enable_mask;
                        snap_mode <= mode;
                        back      <= '0;
                        pix       <= '0;
                        col       <= '0;
                        row       <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    back[pix] <= |hits;
                    if (pix == PIX_W'(NPIX - 1)) begin
                        state <= COMMIT;
                    end else begin
                        pix <= pix + 1'b1;
                        if (col == COL_W'(GRID_W - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    matrix      <= (snap_mode == MODE_PERSIST) ? (matrix | back) : back;
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_particle_raster.sv
`default_nettype none
// ============================================================================
// Module   : tb_particle_raster
// Purpose  : Directed self-checking bench for particle_raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_particle_raster;

    localparam int NP   = 4;
    localparam int CW   = 16;
    localparam int NPIX = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              reset2 = 1'b1;
    logic [NP*2*CW-1:0] pos = '0;
    logic [NP-1:0]     enable_mask = '0;
    logic [1:0]        mode = 2'b00;

    logic [NPIX-1:0]   matrix, matrix2;
    logic              frame_valid, busy, overrun;
    logic              frame_valid2, busy2, overrun2;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int edge_cnt2 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt  <= reset  ? 0 : edge_cnt + 1;
        edge_cnt2 <= reset2 ? 0 : edge_cnt2 + 1;
    end

    particle_raster #(.WAIT_CYCLES(300)) dut (
        .clk(clk), .reset(reset), .pos(pos), .enable_mask(enable_mask), .mode(mode),
        .matrix(matrix), .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
    );

    particle_raster #(.WAIT_CYCLES(100)) dut_ov (
        .clk(clk), .reset(reset2), .pos(pos), .enable_mask(enable_mask), .mode(mode),
        .matrix(matrix2), .frame_valid(frame_valid2), .busy(busy2), .overrun(overrun2)
    );

    function automatic logic [NPIX-1:0] blk(input int cx, input int cy);
        logic [NPIX-1:0] m;
        m = '0;
        for (int y = cy - 1; y <= cy + 1; y++)
            for (int x = cx - 1; x <= cx + 1; x++)
                if (x >= 0 && x < 16 && y >= 0 && y < 16) m[y*16 + x] = 1'b1;
        return m;
    endfunction

    task automatic set_p(input int i, input int x, input int y);
        pos[32*i +: 16]      = 16'(x);
        pos[32*i + 16 +: 16] = 16'(y);
    endtask

    task automatic run_frame(input int limit, output int fv_edge,
                             output int busy_first, output int busy_cnt);
        fv_edge = -1; busy_first = -1; busy_cnt = 0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = edge_cnt;
            end
            if (frame_valid) begin
                fv_edge = edge_cnt;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (matrix !== '0) begin errors++; $display("FAIL reset_matrix got=%h want=0", matrix); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_disc;
        int fv, bf, bc;
        set_p(0, 128, 128);
        set_p(1, 32, 32);
        enable_mask = 4'b0001;
        mode = 2'b00;
        run_frame(1000, fv, bf, bc);
        checks++; if (bf !== 300) begin errors++; $display("FAIL disc_busy_start got=%0d want=300", bf); end
        checks++; if (bc !== 257) begin errors++; $display("FAIL disc_busy_len got=%0d want=257", bc); end
        checks++; if (fv !== 557) begin errors++; $display("FAIL disc_fv_edge got=%0d want=557", fv); end
        checks++; if (matrix !== blk(8, 8)) begin errors++; $display("FAIL disc_matrix got=%h want=%h", matrix, blk(8, 8)); end
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL disc_fv_pulse got=%b want=0", frame_valid); end
    endtask

    task automatic test_ring_centre;
        int fv, bf, bc;
        logic [NPIX-1:0] exp_m;
        mode = 2'b01;
        run_frame(1000, fv, bf, bc);
        exp_m = blk(8, 8);
        exp_m[136] = 1'b0;
        checks++; if (fv !== 857) begin errors++; $display("FAIL ring_fv_edge got=%0d want=857", fv); end
        checks++; if (matrix !== exp_m) begin errors++; $display("FAIL ring_matrix got=%h want=%h", matrix, exp_m); end
        mode = 2'b10;
        run_frame(1000, fv, bf, bc);
        exp_m = '0;
        exp_m[136] = 1'b1;
        checks++; if (matrix !== exp_m) begin errors++; $display("FAIL centre_matrix got=%h want=%h", matrix, exp_m); end
    endtask

    task automatic test_offgrid;
        int fv, bf, bc;
        logic [NPIX-1:0] exp_m;
        mode = 2'b00;
        set_p(0, -16, 128);
        run_frame(1000, fv, bf, bc);
        exp_m = '0;
        exp_m[112] = 1'b1; exp_m[128] = 1'b1; exp_m[144] = 1'b1;
        checks++; if (matrix !== exp_m) begin errors++; $display("FAIL edge_col0 got=%h want=%h", matrix, exp_m); end
        set_p(0, -64, -64);
        run_frame(1000, fv, bf, bc);
        checks++; if (matrix !== '0) begin errors++; $display("FAIL offgrid got=%h want=0", matrix); end
    endtask

    task automatic test_persist;
        int fv, bf, bc;
        mode = 2'b11;
        set_p(0, 32, 32);
        run_frame(1000, fv, bf, bc);
        checks++; if (matrix !== blk(2, 2)) begin errors++; $display("FAIL persist_a got=%h want=%h", matrix, blk(2, 2)); end
        set_p(0, 224, 224);
        run_frame(1000, fv, bf, bc);
        checks++; if (matrix !== (blk(2, 2) | blk(14, 14))) begin errors++; $display("FAIL persist_b got=%h want=%h", matrix, blk(2, 2) | blk(14, 14)); end
        checks++; if ($countones(matrix) !== 18) begin errors++; $display("FAIL persist_count got=%0d want=18", $countones(matrix)); end
        mode = 2'b00;
        run_frame(1000, fv, bf, bc);
        checks++; if (matrix !== blk(14, 14)) begin errors++; $display("FAIL persist_clear got=%h want=%h", matrix, blk(14, 14)); end
        checks++; if (fv !== 2657) begin errors++; $display("FAIL persist_fv_edge got=%0d want=2657", fv); end
    endtask

    task automatic test_snapshot;
        int fv, bf, bc;
        bit seen;
        set_p(0, 128, 128);
        mode = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL snap_busy got=%b want=1", seen); end
        repeat (5) @(posedge clk);
        #1;
        set_p(0, 32, 32);
        mode = 2'b10;
        enable_mask = 4'b0000;
        run_frame(1000, fv, bf, bc);
        checks++; if (matrix !== blk(8, 8)) begin errors++; $display("FAIL snapshot got=%h want=%h", matrix, blk(8, 8)); end
        set_p(0, 128, 128);
        mode = 2'b00;
        enable_mask = 4'b0001;
    endtask

    task automatic test_reset_midscan;
        int fv, bf, bc;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
        end
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (matrix !== '0) begin errors++; $display("FAIL midreset_matrix got=%h want=0", matrix); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
        run_frame(1000, fv, bf, bc);
        checks++; if (bf !== 300) begin errors++; $display("FAIL midreset_busy_start got=%0d want=300", bf); end
        checks++; if (fv !== 557) begin errors++; $display("FAIL midreset_fv_edge got=%0d want=557", fv); end
        checks++; if (matrix !== blk(8, 8)) begin errors++; $display("FAIL midreset_matrix2 got=%h want=%h", matrix, blk(8, 8)); end
    endtask

    task automatic test_overrun;
        int fv1, fv2;
        fv1 = -1; fv2 = -1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        for (int k = 0; k < 700; k++) begin
            @(posedge clk); #1;
            if (edge_cnt2 == 199) begin
                checks++; if (overrun2 !== 1'b0) begin errors++; $display("FAIL ovr_before got=%b want=0", overrun2); end
            end
            if (edge_cnt2 == 200) begin
                checks++; if (overrun2 !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want=1", overrun2); end
            end
            if (frame_valid2) begin
                if (fv1 < 0) fv1 = edge_cnt2;
                else if (fv2 < 0) fv2 = edge_cnt2;
            end
        end
        checks++; if (fv1 !== 357) begin errors++; $display("FAIL ovr_fv1 got=%0d want=357", fv1); end
        checks++; if (fv2 !== 657) begin errors++; $display("FAIL ovr_fv2 got=%0d want=657", fv2); end
        checks++; if (matrix2 !== blk(8, 8)) begin errors++; $display("FAIL ovr_matrix got=%h want=%h", matrix2, blk(8, 8)); end
        checks++; if (overrun2 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b want=1", overrun2); end
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        checks++; if (overrun2 !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want=0", overrun2); end
    endtask

    initial begin
        test_reset();
        test_disc();
        test_ring_centre();
        test_offgrid();
        test_persist();
        test_snapshot();
        test_reset_midscan();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/particle_raster.md
# particle_raster

Time-multiplexed, parametrised renderer that turns N signed fixed-point particle positions into a GRID_W×GRID_H LED bitmap. It evaluates one pixel per cycle against all enabled particles instead of instantiating a distance checker per pixel per particle. Output is double-buffered and committed at a programmable frame rate. It sits between the physics particles and the LED matrix driver, and supports filled-disc, ring, centre-only and persistence (trail) modes.

## Interface
- N_PART, 4, number of particles
- COORD_W, 16, signed coordinate width
- FRAC_BITS, 4, fractional bits; grid coordinate = coord >>> FRAC_BITS (arithmetic)
- GRID_W, 16, matrix columns
- GRID_H, 16, matrix rows
- R2, 2, outer squared radius (inclusive)
- R2_IN, 1, inner squared radius for ring mode (inclusive)
- WAIT_CYCLES, 10000, frame period in clocks; legal when ≥ GRID_W*GRID_H+2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pos  in  N_PART*2*COORD_W  packed {y,x} per particle; particle i at [2*COORD_W*i +: 2*COORD_W], x in low half
- enable_mask  in  N_PART  bit i=1 includes particle i
- mode  in  2  00 filled disc, 01 ring, 10 centre only, 11 persist (filled disc OR'd onto previous frame)
- matrix  out  GRID_W*GRID_H  bit (y*GRID_W+x) = pixel at column x, row y
- frame_valid  out  1  one-cycle pulse after each commit
- busy  out  1  high while a frame is being rasterised
- overrun  out  1  sticky; a frame tick arrived while busy

## Operation
- Frame counter: 0 after reset, +1 per cycle, wraps at WAIT_CYCLES-1 → 0; tick = (counter == WAIT_CYCLES-1).
- FSM states: IDLE, SCAN, COMMIT.
- IDLE → SCAN on tick. Same edge: snapshot pos, enable_mask and mode into registers, clear back buffer, set pixel index p=0. Later input changes do not affect the frame in progress.
- SCAN: each cycle evaluate pixel p. px = p mod GRID_W, py = p / GRID_W; use row/column counters, not a divider.
  - Per particle: gx = x>>>FRAC_BITS, gy = y>>>FRAC_BITS, dx = px-gx, dy = py-gy, signed COORD_W+1 bits.
  - d2 = dx²+dy², unsigned 2*(COORD_W+1) bits, no truncation.
  - hit: disc/persist d2 ≤ R2; ring R2_IN ≤ d2 ≤ R2; centre d2 == 0. Disabled particles never hit.
  - Write the OR of hits to back[p]. On p = GRID_W*GRID_H-1 go to COMMIT.
- COMMIT: matrix ← back, or matrix | back if the snapshotted mode is 11. Pulse frame_valid, return to IDLE.
- Persist accumulates until a frame is committed in another mode; that frame overwrites.
- Off-grid or negative grid coordinates are legal; only on-grid pixels within radius light. Particles entirely off grid contribute nothing.
- A tick while busy is dropped (no restart, no queue) and sets overrun. overrun clears only on reset.

## Timing
- Reset values: matrix 0, frame_valid 0, busy 0, overrun 0, counter 0, state IDLE, back buffer 0.
- Reset asserted mid-scan aborts the frame. matrix reads 0 on the cycle after the reset edge, and no frame_valid is produced.
- Edge k = k-th rising edge after reset deasserts. First tick is evaluated at edge WAIT_CYCLES (snapshot edge T).
- busy is high from edge T to edge T+NPIX+1, where NPIX = GRID_W*GRID_H. matrix is updated at edge T+NPIX+1. frame_valid is high for the cycle following that edge.
- Steady-state frame period is exactly WAIT_CYCLES cycles. matrix is stable between commits.

## Test plan
- Defaults except WAIT_CYCLES=300; only particle 0 enabled at (128,128), mode 00 → after first frame_valid, exactly bits y∈{7,8,9}, x∈{7,8,9} set (9 bits, e.g. bit 136); busy high 257 cycles.
- Same position, mode 01 → 8 bits: 3×3 block minus bit 136. Mode 10 → only bit 136.
- Particle 0 at (x=-16,y=128), mode 00 → bits 112, 128, 144 only (column 0, rows 7–9). Particle at (-64,-64) → matrix all 0.
- Mode 11, particle moved from (32,32) to (224,224) between frames → second commit holds both 3×3 blocks (18 bits). Next frame in mode 00 → only the (14,14) block.
- Change pos during SCAN → committed frame reflects the snapshot only. Assert reset mid-SCAN → matrix 0, no frame_valid, next frame starts WAIT_CYCLES edges after release.
- WAIT_CYCLES=100 → overrun set at the first tick during busy and stays 1. Commits continue on accepted ticks; reset clears overrun.
